// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: grants one whole AXI4-Lite transaction at a time to m0 (IFU) or m1 (LSU) on a shared slave port
module axi_lite_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [1:0]          m0_rresp,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  output logic [1:0]          m0_bresp,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [1:0]          m1_rresp,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [1:0]          s_rresp,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  output logic [1:0]          grant,
  output logic                timeout_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam bit WD_EN = TIMEOUT > 0;
  typedef enum logic [1:0] {IDLE, RD_GNT, WR_GNT} state_t;
  state_t state, state_n;
  logic own, last, aw_done, w_done;
  logic [CW-1:0] cnt;
  logic req0, req1, req, win, win_rd, rd, wr, g0, g1, rd_fin, wr_fin;
  logic o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
  logic [ADDR_W-1:0] o_araddr, o_awaddr;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W/8-1:0] o_wstrb;
  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;
  assign req = req0 | req1;
  // last holds the previous winner, so the other side wins a tie
  assign win = (RR_EN != 0 && req0 && req1) ? ~last : req1;
  assign win_rd = win ? m1_arvalid : m0_arvalid;
  assign rd = state == RD_GNT;
  assign wr = state == WR_GNT;
  assign g0 = state != IDLE && !own;
  assign g1 = state != IDLE && own;
  assign grant = {g1, g0};
  assign o_arvalid = own ? m1_arvalid : m0_arvalid;
  assign o_araddr  = own ? m1_araddr  : m0_araddr;
  assign o_rready  = own ? m1_rready  : m0_rready;
  assign o_awvalid = own ? m1_awvalid : m0_awvalid;
  assign o_awaddr  = own ? m1_awaddr  : m0_awaddr;
  assign o_wvalid  = own ? m1_wvalid  : m0_wvalid;
  assign o_wdata   = own ? m1_wdata   : m0_wdata;
  assign o_wstrb   = own ? m1_wstrb   : m0_wstrb;
  assign o_bready  = own ? m1_bready  : m0_bready;
  assign s_arvalid = rd & o_arvalid;
  assign s_araddr  = rd ? o_araddr : '0;
  assign s_rready  = rd & o_rready;
  assign s_awvalid = wr & ~aw_done & o_awvalid;
  assign s_awaddr  = wr ? o_awaddr : '0;
  assign s_wvalid  = wr & ~w_done & o_wvalid;
  assign s_wdata   = wr ? o_wdata : '0;
  assign s_wstrb   = wr ? o_wstrb : '0;
  assign s_bready  = wr & o_bready;
  assign rd_fin = rd & s_rvalid & s_rready;
  assign wr_fin = wr & s_bvalid & s_bready;
  assign m0_arready = g0 & rd & s_arready;
  assign m0_rvalid  = g0 & rd & s_rvalid;
  assign m0_rresp   = (g0 & rd) ? s_rresp : '0;
  assign m0_rdata   = (g0 & rd) ? s_rdata : '0;
  assign m0_awready = g0 & wr & ~aw_done & s_awready;
  assign m0_wready  = g0 & wr & ~w_done & s_wready;
  assign m0_bvalid  = g0 & wr & s_bvalid;
  assign m0_bresp   = (g0 & wr) ? s_bresp : '0;
  assign m1_arready = g1 & rd & s_arready;
  assign m1_rvalid  = g1 & rd & s_rvalid;
  assign m1_rresp   = (g1 & rd) ? s_rresp : '0;
  assign m1_rdata   = (g1 & rd) ? s_rdata : '0;
  assign m1_awready = g1 & wr & ~aw_done & s_awready;
  assign m1_wready  = g1 & wr & ~w_done & s_wready;
  assign m1_bvalid  = g1 & wr & s_bvalid;
  assign m1_bresp   = (g1 & wr) ? s_bresp : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? (win_rd ? RD_GNT : WR_GNT) : IDLE;
      RD_GNT:  state_n = rd_fin ? IDLE : RD_GNT;
      WR_GNT:  state_n = wr_fin ? IDLE : WR_GNT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      own <= 1'b0;
      last <= 1'b1;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt <= '0;
        if (req) begin
          own <= win;
          last <= win;
          aw_done <= 1'b0;
          w_done <= 1'b0;
        end
      end else begin
        if (s_awvalid && s_awready) aw_done <= 1'b1;
        if (s_wvalid && s_wready) w_done <= 1'b1;
        // watchdog only flags; the transaction keeps waiting for the slave
        if (rd_fin || wr_fin) cnt <= '0;
        else if (cnt != TO) cnt <= cnt + 1'b1;
        if (WD_EN && !rd_fin && !wr_fin && cnt + 1'b1 == TO) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scenarios plus randomized two-master rounds scored against a transaction-level model
module tb_axi_lite_arbiter;
  logic clk = 0, rst;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
  logic [3:0] m0_wstrb;
  logic [1:0] m0_rresp, m0_bresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic [3:0] m1_wstrb;
  logic [1:0] m1_rresp, m1_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_rresp, s_bresp, grant;
  logic timeout_err;
  logic f0_arready, f0_rvalid, f0_awready, f0_wready, f0_bvalid, f1_arready, f1_rvalid, f1_awready, f1_wready, f1_bvalid;
  logic [1:0] f0_rresp, f0_bresp, f1_rresp, f1_bresp, f_grant;
  logic [31:0] f0_rdata, f1_rdata, fs_araddr, fs_awaddr, fs_wdata;
  logic fs_arvalid, fs_rready, fs_awvalid, fs_wvalid, fs_bready, f_err;
  logic [3:0] fs_wstrb;
  int vecs = 0, errs = 0;
  logic last_m;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rresp(m0_rresp), .m0_rdata(m0_rdata), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready), .m0_bresp(m0_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rresp(m1_rresp), .m1_rdata(m1_rdata), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rresp(s_rresp), .s_rdata(s_rdata), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_bresp(s_bresp), .grant(grant), .timeout_err(timeout_err)
  );

  // fixed-priority instance shares the masters; its slave always answers at once
  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(f0_arready), .m0_araddr(m0_araddr), .m0_rvalid(f0_rvalid), .m0_rready(m0_rready),
    .m0_rresp(f0_rresp), .m0_rdata(f0_rdata), .m0_awvalid(m0_awvalid), .m0_awready(f0_awready), .m0_awaddr(m0_awaddr),
    .m0_wvalid(m0_wvalid), .m0_wready(f0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_bvalid(f0_bvalid),
    .m0_bready(m0_bready), .m0_bresp(f0_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(f1_arready), .m1_araddr(m1_araddr), .m1_rvalid(f1_rvalid), .m1_rready(m1_rready),
    .m1_rresp(f1_rresp), .m1_rdata(f1_rdata), .m1_awvalid(m1_awvalid), .m1_awready(f1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(f1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_bvalid(f1_bvalid),
    .m1_bready(m1_bready), .m1_bresp(f1_bresp),
    .s_arvalid(fs_arvalid), .s_arready(1'b1), .s_araddr(fs_araddr), .s_rvalid(1'b1), .s_rready(fs_rready),
    .s_rresp(2'b00), .s_rdata(32'h0), .s_awvalid(fs_awvalid), .s_awready(1'b1), .s_awaddr(fs_awaddr),
    .s_wvalid(fs_wvalid), .s_wready(1'b1), .s_wdata(fs_wdata), .s_wstrb(fs_wstrb), .s_bvalid(1'b1),
    .s_bready(fs_bready), .s_bresp(2'b00), .grant(f_grant), .timeout_err(f_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {m0_arvalid, m0_awvalid, m0_wvalid, m1_arvalid, m1_awvalid, m1_wvalid} = '0;
    {m0_araddr, m0_awaddr, m0_wdata, m1_araddr, m1_awaddr, m1_wdata} = '0;
    m0_wstrb = '0; m1_wstrb = '0;
    {m0_rready, m0_bready, m1_rready, m1_bready} = '1;
    {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
    s_rdata = '0; s_rresp = '0; s_bresp = '0;
  endtask

  // kinds: 0 idle, 1 read, 2 write; each active master performs exactly one transaction
  task automatic run_round(input int k0, input int k1);
    int kd[2], rcnt, bcnt, cur, cyc, w;
    bit ar_p[2], aw_p[2], w_p[2], busy[2], srv[2], sa, sw, pdone;
    logic [31:0] addr[2], wd[2], rdat;
    logic [1:0] rsp;
    kd[0] = k0; kd[1] = k1;
    for (int i = 0; i < 2; i++) begin
      busy[i] = kd[i] != 0; srv[i] = 0; ar_p[i] = kd[i] == 1; aw_p[i] = kd[i] == 2; w_p[i] = kd[i] == 2;
      addr[i] = $urandom; wd[i] = $urandom;
    end
    rcnt = -1; bcnt = -1; cur = -1; cyc = 0; sa = 0; sw = 0; pdone = 0; rdat = $urandom; rsp = 2'($urandom);
    while ((busy[0] || busy[1]) && cyc < 300) begin
      cyc++;
      tick();
      m0_arvalid = ar_p[0]; m0_araddr = addr[0]; m0_awvalid = aw_p[0]; m0_awaddr = addr[0];
      m0_wvalid = w_p[0]; m0_wdata = wd[0]; m0_wstrb = 4'hf;
      m1_arvalid = ar_p[1]; m1_araddr = addr[1]; m1_awvalid = aw_p[1]; m1_awaddr = addr[1];
      m1_wvalid = w_p[1]; m1_wdata = wd[1]; m1_wstrb = 4'hf;
      s_arready = 1'($urandom); s_awready = 1'($urandom); s_wready = 1'($urandom);
      s_rvalid = rcnt == 0; s_rdata = rdat; s_rresp = rsp; s_bvalid = bcnt == 0; s_bresp = rsp;
      #2;
      if (pdone) chk("bubble", grant, 0);
      pdone = 0;
      if (cur < 0) begin
        if (grant != 0) begin
          w = (busy[0] && !srv[0] && busy[1] && !srv[1]) ? int'(!last_m) : (busy[1] && !srv[1]) ? 1 : 0;
          chk("winner", grant, w ? 2 : 1);
          chk("kind", {s_arvalid, s_awvalid}, kd[w] == 1 ? 2'b10 : 2'b01);
          last_m = w[0]; cur = w; srv[w] = 1;
        end
      end else chk("hold", grant, cur ? 2 : 1);
      if (cur >= 0) begin
        chk("nonown", cur ? {m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid}
                          : {m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 0);
        if (s_rvalid && s_rready) begin
          chk("rvalid", cur ? m1_rvalid : m0_rvalid, 1);
          chk("rdata", cur ? m1_rdata : m0_rdata, rdat);
          chk("rresp", cur ? m1_rresp : m0_rresp, rsp);
          busy[cur] = 0; cur = -1; pdone = 1;
        end else if (s_bvalid && s_bready) begin
          chk("bvalid", cur ? m1_bvalid : m0_bvalid, 1);
          chk("bresp", cur ? m1_bresp : m0_bresp, rsp);
          busy[cur] = 0; cur = -1; pdone = 1;
        end else begin
          if (rcnt > 0) rcnt--;
          if (bcnt > 0) bcnt--;
          if (s_arvalid && s_arready) begin
            chk("araddr", s_araddr, addr[cur]);
            chk("arready", cur ? m1_arready : m0_arready, 1);
            ar_p[cur] = 0; rcnt = $urandom_range(0, 2);
          end
          if (s_awvalid && s_awready) begin
            chk("awaddr", s_awaddr, addr[cur]);
            chk("aw_once", sa, 0);
            sa = 1; aw_p[cur] = 0;
          end
          if (s_wvalid && s_wready) begin
            chk("wdata", s_wdata, wd[cur]);
            chk("w_once", sw, 0);
            sw = 1; w_p[cur] = 0;
          end
          if (sa && sw && bcnt < 0) bcnt = $urandom_range(0, 2);
        end
        if (pdone) begin
          sa = 0; sw = 0; rcnt = -1; bcnt = -1; rdat = $urandom; rsp = 2'($urandom);
        end
      end
    end
    chk("round_done", {busy[0], busy[1]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k0, k1;
    rst = 0;
    clr();
    repeat (3) tick();
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
    // single read from m0
    tick();
    rst = 1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; s_arready = 1;
    #2;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_fwd", s_arvalid, 0);
    tick(); #2;
    chk("t1_grant", grant, 2'b01);
    chk("t1_araddr", s_araddr, 32'h8000_0000);
    chk("t1_arready", {m0_arready, m1_arready}, 2'b10);
    tick();
    m0_arvalid = 0; s_arready = 0;
    #2;
    chk("t1_wait", grant, 2'b01);
    tick();
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = 0;
    #2;
    chk("t1_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_rvalid", {m0_rvalid, m1_rvalid, s_rready}, 3'b101);
    tick();
    s_rvalid = 0;
    #2;
    chk("t1_done", grant, 0);
    // simultaneous reads after reset: m0 first, then m1 after a bubble
    tick(); rst = 0; clr();
    tick(); rst = 1; last_m = 1;
    run_round(1, 1);
    // m1 write with W accepted three cycles before AW
    tick(); clr();
    m1_awvalid = 1; m1_awaddr = 32'h8000_0010; m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011;
    #2;
    chk("t3_idle", grant, 0);
    tick(); s_wready = 1; #2;
    chk("t3_grant", grant, 2'b10);
    chk("t3_w", {s_wvalid, m1_wready, m0_wready}, 3'b110);
    chk("t3_wdata", {s_wdata, 28'h0, s_wstrb}, {32'hDEAD_BEEF, 28'h0, 4'b0011});
    tick(); s_wready = 0; #2;
    chk("t3_wdrop", {s_wvalid, s_awvalid}, 2'b01);
    tick(); #2;
    chk("t3_wdrop2", s_wvalid, 0);
    tick(); s_awready = 1; #2;
    chk("t3_awaddr", s_awaddr, 32'h8000_0010);
    chk("t3_awready", m1_awready, 1);
    tick(); s_awready = 0; s_bvalid = 1; s_bresp = 2'b00; #2;
    chk("t3_awdrop", s_awvalid, 0);
    chk("t3_b", {m1_bvalid, m0_bvalid, m1_bresp}, 4'b1000);
    tick(); s_bvalid = 0; m1_awvalid = 0; m1_wvalid = 0; #2;
    chk("t3_done", grant, 0);
    // m1 read+write together: read first, write on the next grant
    tick(); clr();
    m1_arvalid = 1; m1_araddr = 32'h100; m1_awvalid = 1; m1_awaddr = 32'h200; m1_wvalid = 1; m1_wdata = 32'h55;
    m1_wstrb = 4'hf; s_arready = 1; s_awready = 1; s_wready = 1;
    #2;
    chk("t4_idle", grant, 0);
    tick(); #2;
    chk("t4_rd_first", {grant, s_arvalid, s_awvalid, s_wvalid}, 5'b10100);
    tick(); m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001; #2;
    chk("t4_rdata", {m1_rvalid, m1_rdata}, {1'b1, 32'hCAFE_0001});
    tick(); s_rvalid = 0; #2;
    chk("t4_bubble", grant, 0);
    tick(); #2;
    chk("t4_wr_next", {grant, s_arvalid, s_awvalid, s_wvalid}, 5'b10011);
    tick(); m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; #2;
    chk("t4_b", m1_bvalid, 1);
    tick(); clr(); #2;
    chk("t4_done", grant, 0);
    // fixed priority: m1 takes every grant while both request
    tick();
    m0_arvalid = 1; m1_arvalid = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); #2;
      chk("fp_no_m0", f_grant[0], 0);
      if (f_grant == 2'b10) n++;
    end
    chk("fp_grants", n, 10);
    // watchdog on a silent slave
    tick(); rst = 0; clr();
    tick(); rst = 1; #2;
    chk("t5_err0", timeout_err, 0);
    m0_arvalid = 1;
    for (int k = 1; k <= 15; k++) begin
      tick(); #2;
      chk("t5_err", timeout_err, k >= 9);
      chk("t5_grant", grant, 2'b01);
    end
    tick(); rst = 0;
    tick(); rst = 1; #2;
    chk("t5_rst", {timeout_err, grant, s_arvalid, s_awvalid, s_wvalid, m0_arready, m0_rvalid}, 0);
    m0_arvalid = 0;
    // randomized rounds
    tick(); rst = 0; clr();
    tick(); rst = 1; last_m = 1;
    for (int r = 0; r < 40; r++) begin
      k0 = $urandom_range(0, 2);
      k1 = $urandom_range(0, 2);
      if (k0 == 0 && k1 == 0) k0 = 1;
      run_round(k0, k1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
